mmio_uart_tx: RTL

Memory-mapped serial transmitter peripheral on the processor's data-memory store/load interface, decoded alongside the timer at virtual MMIO addresses. It accepts byte stores from the CPU into a FIFO, serializes them onto a single 8N1 line, and raises a maskable interrupt when the transmitter drains, to be routed to cp0. It is a pure responder: it never stalls the CPU; stores to a full FIFO are dropped and flagged.

---
 rtl/mmio_uart_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: CPU byte stores feed a TX FIFO that a
// serializer drains onto `tx`; a maskable drain interrupt is raised when the line goes idle.
module mmio_uart_tx #(
  parameter int unsigned      width        = 64,
  parameter int unsigned      CLKS_PER_BIT = 4,
  parameter int unsigned      FIFO_DEPTH   = 8,
  parameter logic [width-1:0] TX_DATA_ADDR = width'(64'hFFFF0080),
  parameter logic [width-1:0] STATUS_ADDR  = width'(64'hFFFF0084),
  parameter logic [width-1:0] CTRL_ADDR    = width'(64'hFFFF0088)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] address,
  input  logic [width-1:0] data,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             uart_address,
  output logic [width-1:0] rd_data,
  output logic             uart_interrupt,
  output logic             tx
);

  localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STAT_W = 10;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_pending_q, irq_pending_d;
  logic             irq_enable_q, irq_enable_d;
  logic             overflow_q, overflow_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic              hit_tx_c, hit_status_c, hit_ctrl_c;
  logic              wr_tx_c, wr_ctrl_c;
  logic              pop_c, push_c, drop_c, set_irq_c;
  logic [STAT_W-1:0] status_c;
  logic              unused_data_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Full-width address decode
  assign hit_tx_c     = (address == TX_DATA_ADDR);
  assign hit_status_c = (address == STATUS_ADDR);
  assign hit_ctrl_c   = (address == CTRL_ADDR);
  assign wr_tx_c      = mem_write & hit_tx_c;
  assign wr_ctrl_c    = mem_write & hit_ctrl_c;
  assign uart_address = hit_tx_c | hit_status_c | hit_ctrl_c;
  assign unused_data_c = ^data[width-1:8];

  // Status reflects pre-edge register values
  assign status_c = {irq_enable_q, overflow_q, irq_pending_q, (state_q != S_IDLE),
                     (count_q == CNT_FULL), (count_q == '0), 4'(count_q)};
  assign rd_data  = (mem_read && hit_status_c) ? width'(status_c) : '0;

  assign tx             = tx_q;
  assign uart_interrupt = irq_q;

  // Serializer next state, FIFO bookkeeping and control registers
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;
    irq_enable_d  = irq_enable_q;
    overflow_d    = overflow_q;
    pop_c         = 1'b0;
    set_irq_c     = 1'b0;
    push_c        = 1'b0;
    drop_c        = 1'b0;
    tx_d          = 1'b1;
    irq_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_c     = 1'b1;
          shift_d   = fifo_q[rd_ptr_q];
          cyc_d     = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          // Chain straight into the next start bit when more data is queued
          if (count_q != '0) begin
            pop_c     = 1'b1;
            shift_d   = fifo_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = S_START;
          end else begin
            set_irq_c = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_c = wr_tx_c && ((count_q != CNT_FULL) || pop_c);
    drop_c = wr_tx_c && !push_c;

    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push_c) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    if (wr_ctrl_c) begin
      irq_enable_d = data[0];
      if (data[1]) begin
        irq_pending_d = 1'b0;
      end
      if (data[2]) begin
        overflow_d = 1'b0;
      end
    end
    // A drain event beats a same-cycle software clear
    if (set_irq_c) begin
      irq_pending_d = 1'b1;
    end
    if (drop_c) begin
      overflow_d = 1'b1;
    end

    // Line level registered from next state so tx never sees bus logic
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = irq_pending_d & irq_enable_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
      irq_enable_q  <= 1'b0;
      overflow_q    <= 1'b0;
      tx_q          <= 1'b1;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
      irq_enable_q  <= irq_enable_d;
      overflow_q    <= overflow_d;
      tx_q          <= tx_d;
      irq_q         <= irq_d;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= data[7:0];
    end
  end

endmodule
